// File: rtl/retire_trace_encoder_pkg.sv
// Shared types for the retire trace encoder.
//   kind_e  : record kind encoding seen by the trace sink
//   state_e : encoder control states
//   rec_t   : packed record payload (everything except the instruction number)
//   classify: turns one retire event into a record, zeroing unused fields
package retire_trace_encoder_pkg;

    typedef enum logic [2:0] {
        KIND_REG  = 3'd0,
        KIND_LD   = 3'd1,
        KIND_ST   = 3'd2,
        KIND_NOP  = 3'd3,
        KIND_HALT = 3'd4
    } kind_e;

    typedef enum logic [1:0] {
        S_RUN,
        S_HALT_PEND,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam int PC_W   = 16;
    localparam int REG_W  = 4;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    // Field order fixes the bit offsets: addr at [15:0], data at [31:16],
    // wreg at [35:32], pc at [51:36], kind at [54:52].
    typedef struct packed {
        kind_e             kind;
        logic [PC_W-1:0]   pc;
        logic [REG_W-1:0]  wreg;
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
    } rec_t;

    localparam int REC_W = $bits(rec_t);

    // Priority: load beats plain register write, which beats halt, which beats store.
    function automatic rec_t classify(
        input logic [PC_W-1:0]   pc,
        input logic              regwr,
        input logic [REG_W-1:0]  wreg,
        input logic [DATA_W-1:0] wdata,
        input logic              memrd,
        input logic              memwr,
        input logic [ADDR_W-1:0] maddr,
        input logic [DATA_W-1:0] mdata,
        input logic              hlt
    );
        rec_t r;
        r    = '0;
        r.pc = pc;
        if (regwr && memrd) begin
            r.kind = KIND_LD;
            r.wreg = wreg;
            r.data = wdata;
            r.addr = maddr;
        end else if (regwr) begin
            r.kind = KIND_REG;
            r.wreg = wreg;
            r.data = wdata;
        end else if (hlt) begin
            r.kind = KIND_HALT;
        end else if (memwr) begin
            r.kind = KIND_ST;
            r.data = mdata;
            r.addr = maddr;
        end else begin
            r.kind = KIND_NOP;
        end
        return r;
    endfunction

endpackage

// File: rtl/retire_trace_encoder_if.sv
// Retire bus (cpu -> encoder) plus trace stream (encoder -> sink).
//   master : the encoder; consumes ret_* and trc_ready, drives trc_*
//   slave  : the cpu/sink side; drives ret_* and trc_ready, consumes trc_*
interface retire_trace_encoder_if #(
    parameter int INUM_W = 32
);
    logic              ret_valid;
    logic [15:0]       ret_pc;
    logic              ret_regwr;
    logic [3:0]        ret_wreg;
    logic [15:0]       ret_wdata;
    logic              ret_memrd;
    logic              ret_memwr;
    logic [15:0]       ret_maddr;
    logic [15:0]       ret_mdata;
    logic              ret_hlt;

    logic              trc_valid;
    logic              trc_ready;
    logic [2:0]        trc_kind;
    logic [INUM_W-1:0] trc_inum;
    logic [15:0]       trc_pc;
    logic [3:0]        trc_reg;
    logic [15:0]       trc_data;
    logic [15:0]       trc_addr;

    modport master (
        input  ret_valid, ret_pc, ret_regwr, ret_wreg, ret_wdata,
               ret_memrd, ret_memwr, ret_maddr, ret_mdata, ret_hlt, trc_ready,
        output trc_valid, trc_kind, trc_inum, trc_pc, trc_reg, trc_data, trc_addr
    );

    modport slave (
        output ret_valid, ret_pc, ret_regwr, ret_wreg, ret_wdata,
               ret_memrd, ret_memwr, ret_maddr, ret_mdata, ret_hlt, trc_ready,
        input  trc_valid, trc_kind, trc_inum, trc_pc, trc_reg, trc_data, trc_addr
    );
endinterface

// File: rtl/retire_trace_encoder_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on dout whenever
// empty is low. A push while full is accepted only alongside a pop.
//   clk, rst   : clock, synchronous active-high reset (flushes pointers/count)
//   push, din  : write request and data
//   pop        : consume head entry (ignored while empty)
//   dout       : head entry
//   full, empty, count : occupancy
module retire_trace_encoder_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic          doPush, doPop;

    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop)  rdPtr <= rdPtr + AW'(1);
            count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= din;
    end

    assign dout  = mem[rdPtr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/retire_trace_encoder.sv
// Commit trace encoder: one record per retired instruction, tagged with a
// running instruction number, buffered in a FIFO and streamed out on
// valid/ready. A cycle watchdog stops tracing for runaway programs.
//   clk, rst : clock, synchronous active-high reset
//   bus      : retire inputs and trace stream (master side)
//   ovf      : sticky, a record was dropped on a full FIFO
//   drop_cnt : dropped record count, saturating at 255
//   done     : halt delivered (or watchdog fired) and FIFO drained
//   timeout  : sticky, watchdog expired
module retire_trace_encoder
    import retire_trace_encoder_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int INUM_W     = 32,
    parameter int MAX_CYCLES = 100000
) (
    input  logic                   clk,
    input  logic                   rst,
    retire_trace_encoder_if.master bus,
    output logic                   ovf,
    output logic [7:0]             drop_cnt,
    output logic                   done,
    output logic                   timeout
);
    localparam int FW = INUM_W + REC_W;
    localparam int CW = $clog2(DEPTH) + 1;

    state_e            state, stateNxt;
    logic [INUM_W-1:0] inum, cycles;
    logic [FW-1:0]     pendEnt;
    rec_t              retRec, outRec;
    logic [FW-1:0]     fifoDin, fifoDout, outEnt;
    logic [CW-1:0]     fifoCount;
    logic              fifoPush, fifoFull, fifoEmpty;
    logic              retEv, popFire, slotFree, wdFire, dropEv;

    assign retRec = classify(bus.ret_pc, bus.ret_regwr, bus.ret_wreg, bus.ret_wdata,
                             bus.ret_memrd, bus.ret_memwr, bus.ret_maddr, bus.ret_mdata,
                             bus.ret_hlt);

    assign retEv    = bus.ret_valid && (state == S_RUN);
    assign popFire  = !fifoEmpty && bus.trc_ready;
    // A full FIFO still has room when the head leaves in the same cycle.
    assign slotFree = !fifoFull || popFire;
    assign wdFire   = ((state == S_RUN) || (state == S_HALT_PEND)) &&
                      (cycles == INUM_W'(MAX_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= S_RUN;
        else     state <= stateNxt;
    end

    always_comb begin
        stateNxt = state;
        unique case (state)
            S_RUN:       if (retEv && bus.ret_hlt) stateNxt = slotFree ? S_DRAIN : S_HALT_PEND;
            S_HALT_PEND: if (slotFree) stateNxt = S_DRAIN;
            S_DRAIN:     if (fifoCount == '0) stateNxt = S_DONE;
            S_DONE:      stateNxt = S_DONE;
            default:     stateNxt = S_RUN;
        endcase
        // Watchdog wins: any pending halt is abandoned and the FIFO drains.
        if (wdFire) stateNxt = S_DRAIN;
    end

    always_comb begin
        fifoPush = 1'b0;
        fifoDin  = {inum, retRec};
        dropEv   = 1'b0;
        unique case (state)
            S_RUN: begin
                if (retEv) begin
                    if (slotFree)          fifoPush = 1'b1;
                    else if (!bus.ret_hlt) dropEv   = 1'b1;
                end
            end
            S_HALT_PEND: begin
                fifoDin  = pendEnt;
                fifoPush = slotFree;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inum     <= '0;
            cycles   <= '0;
            pendEnt  <= '0;
            ovf      <= 1'b0;
            drop_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            if (retEv) inum <= inum + INUM_W'(1);
            // Captured unconditionally on halt; only consumed in HALT_PEND.
            if (retEv && bus.ret_hlt) pendEnt <= {inum, retRec};
            if ((state == S_RUN) || (state == S_HALT_PEND)) cycles <= cycles + INUM_W'(1);
            if (wdFire) timeout <= 1'b1;
            if (dropEv) begin
                ovf <= 1'b1;
                if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    retire_trace_encoder_fifo #(.DEPTH(DEPTH), .W(FW)) uFifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifoPush),
        .pop   (popFire),
        .din   (fifoDin),
        .dout  (fifoDout),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .count (fifoCount)
    );

    // Blank the stream fields when empty so stale storage never shows.
    assign outEnt        = fifoEmpty ? '0 : fifoDout;
    assign outRec        = outEnt[REC_W-1:0];
    assign bus.trc_valid = !fifoEmpty;
    assign bus.trc_inum  = outEnt[FW-1:REC_W];
    assign bus.trc_kind  = outRec.kind;
    assign bus.trc_pc    = outRec.pc;
    assign bus.trc_reg   = outRec.wreg;
    assign bus.trc_data  = outRec.data;
    assign bus.trc_addr  = outRec.addr;
    assign done          = (state == S_DONE);
endmodule

// File: tb/tb_retire_trace_encoder.sv
module tb_retire_trace_encoder;
    localparam int DEPTH  = 8;
    localparam int INUM_W = 32;
    localparam int MAXC   = 50;
    localparam int R_DROP = 0;
    localparam int R_PUSH = 1;
    localparam int R_IGN  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ovf, done, timeout;
    logic [7:0] drop_cnt;

    always #5 clk = ~clk;

    retire_trace_encoder_if #(.INUM_W(INUM_W)) bus ();

    retire_trace_encoder #(.DEPTH(DEPTH), .INUM_W(INUM_W), .MAX_CYCLES(MAXC)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .ovf      (ovf),
        .drop_cnt (drop_cnt),
        .done     (done),
        .timeout  (timeout)
    );

    typedef struct {
        logic [2:0]  kind;
        logic [31:0] inum;
        logic [15:0] pc;
        logic [3:0]  wreg;
        logic [15:0] data;
        logic [15:0] addr;
    } exp_t;

    exp_t        sb[$];
    int          nChk = 0;
    int          nErr = 0;
    logic [31:0] expInum;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChk++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mdl(input logic regwr, memrd, memwr, hlt,
                                 input logic [15:0] pc, input logic [3:0] wreg,
                                 input logic [15:0] wdata, maddr, mdata,
                                 input logic [31:0] inum);
        exp_t e;
        e.inum = inum; e.pc = pc; e.kind = 3'd3; e.wreg = '0; e.data = '0; e.addr = '0;
        if (regwr) begin
            e.wreg = wreg;
            e.data = wdata;
            e.kind = memrd ? 3'd1 : 3'd0;
            if (memrd) e.addr = maddr;
        end else if (hlt) begin
            e.kind = 3'd4;
        end else if (memwr) begin
            e.kind = 3'd2;
            e.data = mdata;
            e.addr = maddr;
        end
        return e;
    endfunction

    // Scoreboard: every accepted record must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.trc_valid && bus.trc_ready) begin
            chk("rec_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk($sformatf("kind@%0d", e.inum), 64'(bus.trc_kind), 64'(e.kind));
                chk($sformatf("inum@%0d", e.inum), 64'(bus.trc_inum), 64'(e.inum));
                chk($sformatf("pc@%0d",   e.inum), 64'(bus.trc_pc),   64'(e.pc));
                chk($sformatf("reg@%0d",  e.inum), 64'(bus.trc_reg),  64'(e.wreg));
                chk($sformatf("data@%0d", e.inum), 64'(bus.trc_data), 64'(e.data));
                chk($sformatf("addr@%0d", e.inum), 64'(bus.trc_addr), 64'(e.addr));
            end
        end
    end

    task automatic doReset(input int n);
        rst = 1'b1;
        bus.ret_valid = 1'b0; bus.trc_ready = 1'b0;
        sb.delete();
        expInum = '0;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Drives one retire for exactly one clock edge; returns at posedge+1.
    task automatic retire(input int mode, input logic regwr, memrd, memwr, hlt,
                          input logic [15:0] pc, input logic [3:0] wreg,
                          input logic [15:0] wdata, maddr, mdata);
        bus.ret_valid = 1'b1; bus.ret_pc = pc; bus.ret_regwr = regwr; bus.ret_wreg = wreg;
        bus.ret_wdata = wdata; bus.ret_memrd = memrd; bus.ret_memwr = memwr;
        bus.ret_maddr = maddr; bus.ret_mdata = mdata; bus.ret_hlt = hlt;
        if (mode == R_PUSH) sb.push_back(mdl(regwr, memrd, memwr, hlt, pc, wreg, wdata, maddr, mdata, expInum));
        if (mode != R_IGN) expInum++;
        @(posedge clk); #1;
        bus.ret_valid = 1'b0;
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int expDrop;
        bus.ret_pc = '0; bus.ret_regwr = 0; bus.ret_wreg = '0; bus.ret_wdata = '0;
        bus.ret_memrd = 0; bus.ret_memwr = 0; bus.ret_maddr = '0; bus.ret_mdata = '0;
        bus.ret_hlt = 0;

        // Reset state
        doReset(2);
        chk("rst_valid", 64'(bus.trc_valid), 0);
        chk("rst_kind", 64'(bus.trc_kind), 0);
        chk("rst_inum", 64'(bus.trc_inum), 0);
        chk("rst_data", 64'(bus.trc_data), 0);
        chk("rst_ovf", 64'(ovf), 0);
        chk("rst_drop", 64'(drop_cnt), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_timeout", 64'(timeout), 0);

        // T1 REG record, one-edge latency
        bus.trc_ready = 1'b1;
        retire(R_PUSH, 1, 0, 0, 0, 16'h0002, 4'd3, 16'h1234, 16'h5555, 16'h6666);
        chk("t1_latency", 64'(bus.trc_valid), 1);
        waitDrain("t1_drain");

        // T2 LD then ST
        doReset(2);
        bus.trc_ready = 1'b1;
        retire(R_PUSH, 1, 1, 0, 0, 16'h0004, 4'd5, 16'hBEEF, 16'h0010, 16'h7777);
        retire(R_PUSH, 0, 0, 1, 0, 16'h0006, 4'd7, 16'h9999, 16'h0020, 16'h00AA);
        retire(R_PUSH, 0, 0, 0, 0, 16'h0008, 4'd2, 16'h1111, 16'h2222, 16'h3333);
        waitDrain("t2_drain");

        // T3 backpressure: 10 retires into 8 slots
        doReset(2);
        for (int i = 0; i < 10; i++)
            retire(i < DEPTH ? R_PUSH : R_DROP, 1, 0, 0, 0, 16'(i * 2), 4'(i), 16'(16'hA000 + i), 0, 0);
        chk("t3_ovf", 64'(ovf), 1);
        chk("t3_drop", 64'(drop_cnt), 2);
        chk("t3_held_inum", 64'(bus.trc_inum), 0);
        bus.trc_ready = 1'b1;
        waitDrain("t3_drain");
        chk("t3_ovf_sticky", 64'(ovf), 1);

        // T4 halt while full -> HALT_PEND, retires ignored, then drain
        doReset(2);
        for (int i = 0; i < DEPTH; i++)
            retire(R_PUSH, 0, 0, 1, 0, 16'(16'h0100 + i), 0, 0, 16'(i), 16'(16'hC000 + i));
        retire(R_PUSH, 0, 0, 0, 1, 16'h0200, 0, 0, 0, 0);
        retire(R_IGN, 1, 0, 0, 0, 16'h0300, 4'd1, 16'hDEAD, 0, 0);
        chk("t4_pend_done", 64'(done), 0);
        chk("t4_pend_drop", 64'(drop_cnt), 0);
        bus.trc_ready = 1'b1;
        waitDrain("t4_drain");
        chk("t4_done_early", 64'(done), 0);
        @(posedge clk); #1;
        chk("t4_done", 64'(done), 1);

        // T5 watchdog at cycle 50
        doReset(2);
        retire(R_PUSH, 1, 0, 0, 0, 16'h0400, 4'd9, 16'h4242, 0, 0);
        repeat (MAXC - 2) @(posedge clk);
        #1 chk("t5_timeout_pre", 64'(timeout), 0);
        @(posedge clk); #1;
        chk("t5_timeout", 64'(timeout), 1);
        retire(R_IGN, 1, 0, 0, 0, 16'h0500, 4'd4, 16'h5151, 0, 0);
        chk("t5_done_pre", 64'(done), 0);
        bus.trc_ready = 1'b1;
        waitDrain("t5_drain");
        @(posedge clk); #1;
        chk("t5_done", 64'(done), 1);

        // T6 reset mid-stream
        doReset(2);
        for (int i = 0; i < 3; i++)
            retire(R_PUSH, 1, 0, 0, 0, 16'(16'h0600 + i), 4'd2, 16'(i), 0, 0);
        chk("t6_valid_pre", 64'(bus.trc_valid), 1);
        doReset(1);
        chk("t6_valid_post", 64'(bus.trc_valid), 0);
        bus.trc_ready = 1'b1;
        retire(R_PUSH, 1, 0, 0, 0, 16'h0700, 4'd6, 16'h6060, 0, 0);
        waitDrain("t6_drain");

        // T7 random mix with random backpressure
        doReset(2);
        expDrop = 0;
        for (int i = 0; i < 30; i++) begin
            bus.trc_ready = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 3) != 0) begin
                int mode;
                mode = (sb.size() >= DEPTH && !bus.trc_ready) ? R_DROP : R_PUSH;
                if (mode == R_DROP) expDrop++;
                retire(mode, 1'($urandom), 1'($urandom), 1'($urandom), 0, 16'($urandom),
                       4'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            end else begin
                @(posedge clk); #1;
            end
        end
        chk("t7_ovf", 64'(ovf), 64'(expDrop != 0));
        chk("t7_drop", 64'(drop_cnt), 64'(expDrop));
        bus.trc_ready = 1'b1;
        waitDrain("t7_drain");

        $display("CHECKS %0d ERRORS %0d", nChk, nErr);
        $finish;
    end
endmodule
